// File: rtl/lmu_pkg.sv
// lmu_pkg: shared widths, response record and helpers for the LMU request front-end.
package lmu_pkg;

    localparam int LMU_DW  = 32;
    localparam int LMU_BEW = 4;

    // One response per accepted request; writes carry zero data.
    typedef struct packed {
        logic              we;
        logic [LMU_DW-1:0] rdata;
    } lmu_rsp_t;

    // Build a response record, forcing the data field to zero for writes.
    function automatic lmu_rsp_t lmu_mk_rsp(input logic we, input logic [LMU_DW-1:0] rdata);
        lmu_rsp_t rsp;
        rsp.we    = we;
        rsp.rdata = we ? {LMU_DW{1'b0}} : rdata;
        return rsp;
    endfunction

endpackage

// File: rtl/lmu_rsp_fifo.sv
// lmu_rsp_fifo: synchronous FIFO of lmu_rsp_t; the head is read from storage flops,
// so a push into an empty FIFO becomes visible one cycle later.
module lmu_rsp_fifo
    import lmu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     push,
    input  lmu_rsp_t push_data,
    input  logic     pop,
    output lmu_rsp_t head,
    output logic     full,
    output logic     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    lmu_rsp_t      mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic          push_s;
    logic          pop_s;

    // Modulo increment so non-power-of-two depths wrap correctly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PTR_LAST) begin
            return {PW{1'b0}};
        end else begin
            return p + PTR_ONE;
        end
    endfunction

    assign full   = (cnt_r == CNT_FULL);
    assign empty  = (cnt_r == {CW{1'b0}});
    assign pop_s  = pop & ~empty;
    assign push_s = push & (~full | pop_s);
    assign head   = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy; simultaneous push and pop are both honoured.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {$bits(lmu_rsp_t){1'b0}};
            end
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_next(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

endmodule

// File: rtl/lmu_rsp_fifo_chk.sv
// lmu_rsp_fifo_chk: protocol checks for the response FIFO.
module lmu_rsp_fifo_chk (
    input logic clk_i,
    input logic rst_i,
    input logic push,
    input logic pop,
    input logic full
);

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full && !pop));

endmodule

// File: rtl/lmu_req_ctrl.sv
// lmu_req_ctrl: request front-end for the LMU single-port SRAM. Drives the RAM pins in
// the accept cycle, tracks read latency and returns in-order responses through a
// credit-protected FIFO so consumer backpressure never drops RAM read data.
module lmu_req_ctrl
    import lmu_pkg::*;
#(
    parameter int NUM_WORDS = 1024,
    parameter int RD_LAT    = 1,
    parameter int RSP_DEPTH = 4,
    localparam int AW       = $clog2(NUM_WORDS)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               req_we_i,
    input  logic [AW-1:0]      req_addr_i,
    input  logic [LMU_DW-1:0]  req_wdata_i,
    input  logic [LMU_BEW-1:0] req_be_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic               rsp_we_o,
    output logic [LMU_DW-1:0]  rsp_rdata_o,
    output logic               sram_req_o,
    output logic               sram_we_o,
    output logic [AW-1:0]      sram_addr_o,
    output logic [LMU_DW-1:0]  sram_wdata_o,
    output logic [LMU_BEW-1:0] sram_be_o,
    input  logic [LMU_DW-1:0]  sram_rdata_i,
    output logic               idle_o
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(RSP_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic               we;
        logic [AW-1:0]      addr;
        logic [LMU_DW-1:0]  wdata;
        logic [LMU_BEW-1:0] be;
    } lmu_req_t;

    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("lmu_req_ctrl: RD_LAT must be 1 or 2");
    end
    if (RSP_DEPTH < (RD_LAT + 1)) begin : g_bad_rsp_depth
        $error("lmu_req_ctrl: RSP_DEPTH must be at least RD_LAT+1");
    end

    logic [CW-1:0]   cnt_r;
    logic [RD_LAT:1] pipe_vld_r;
    logic [RD_LAT:1] pipe_we_r;
    logic            acc_s;
    logic            pop_s;
    logic            push_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    lmu_req_t        sram_s;
    lmu_rsp_t        push_data_s;
    lmu_rsp_t        head_s;

    // Credits cover every request from accept until its response is popped,
    // so the FIFO can never be asked to hold more than RSP_DEPTH entries.
    assign req_ready_o = ~rst_i & (cnt_r < CNT_MAX);
    assign acc_s       = req_valid_i & req_ready_o;
    assign pop_s       = ~fifo_empty_s & rsp_ready_i;
    assign idle_o      = (cnt_r == {CW{1'b0}});

    // Present the accepted request to the RAM; idle pins are held at zero.
    always_comb begin
        sram_s = {$bits(lmu_req_t){1'b0}};
        if (acc_s) begin
            sram_s.we    = req_we_i;
            sram_s.addr  = req_addr_i;
            sram_s.wdata = req_wdata_i;
            sram_s.be    = req_we_i ? req_be_i : {LMU_BEW{1'b0}};
        end else begin
            sram_s = {$bits(lmu_req_t){1'b0}};
        end
    end

    assign sram_req_o   = acc_s;
    assign sram_we_o    = sram_s.we;
    assign sram_addr_o  = sram_s.addr;
    assign sram_wdata_o = sram_s.wdata;
    assign sram_be_o    = sram_s.be;

    // Latency pipe: the last stage lines up with RAM read data for that request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_vld_r <= {RD_LAT{1'b0}};
            pipe_we_r  <= {RD_LAT{1'b0}};
        end else begin
            pipe_vld_r[1] <= acc_s;
            pipe_we_r[1]  <= acc_s & req_we_i;
            for (int k = 2; k <= RD_LAT; k++) begin
                pipe_vld_r[k] <= pipe_vld_r[k-1];
                pipe_we_r[k]  <= pipe_we_r[k-1];
            end
        end
    end

    // Credit counter: +1 per accept, -1 per response consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            case ({acc_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_ONE;
                2'b01:   cnt_r <= cnt_r - CNT_ONE;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign push_s      = pipe_vld_r[RD_LAT];
    assign push_data_s = lmu_mk_rsp(pipe_we_r[RD_LAT], sram_rdata_i);

    lmu_rsp_fifo #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    lmu_rsp_fifo_chk u_rsp_fifo_chk (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push_s),
        .pop   (pop_s),
        .full  (fifo_full_s)
    );

    assign rsp_valid_o = ~fifo_empty_s;
    assign rsp_we_o    = head_s.we;
    assign rsp_rdata_o = head_s.rdata;

endmodule

// File: tb/tb_lmu_req_ctrl.sv
// tb_lmu_req_ctrl: table-driven and sequence tests for lmu_req_ctrl with a behavioural
// SRAM, a shadow memory and a response scoreboard.
module tb_lmu_req_ctrl;
    import lmu_pkg::*;

    localparam int NUM_WORDS = 1024;
    localparam int AW        = 10;
    localparam int RD_LAT    = 2;
    localparam int RSP_DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [31:0]   rsp_rdata;
    logic          sram_req;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [3:0]    sram_be;
    logic [31:0]   sram_rdata;
    logic          idle;

    lmu_req_ctrl #(
        .NUM_WORDS (NUM_WORDS),
        .RD_LAT    (RD_LAT),
        .RSP_DEPTH (RSP_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_we_o     (rsp_we),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata),
        .idle_o       (idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-port SRAM with RD_LAT cycles of read latency.
    logic [31:0] ram [NUM_WORDS];
    logic [31:0] ram_q1;
    logic [31:0] ram_q2;
    always @(posedge clk) begin
        if (sram_req && sram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (sram_be[b]) ram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
        if (sram_req && !sram_we) ram_q1 <= ram[sram_addr];
        ram_q2 <= ram_q1;
    end
    assign sram_rdata = (RD_LAT == 1) ? ram_q1 : ram_q2;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic [31:0]   exp_rd;
    } vec_t;

    exp_t        sb[$];
    logic [31:0] shadow [NUM_WORDS];
    int          total = 0;
    int          bad = 0;
    bit          lat_chk = 1'b1;
    int          last_acc_cyc = 0;
    int          last_pop_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    // Sample on the falling edge and retire any response handed over at the next rising edge.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (!rst && rsp_valid && rsp_ready) begin
            last_pop_cyc = cyc;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got we=%0b data=0x%08h expected no response (cycle %0d)",
                         rsp_we, rsp_rdata, cyc);
            end else begin
                e = sb.pop_front();
                check("rsp_we", 32'(rsp_we), 32'(e.we));
                check("rsp_rdata", rsp_rdata, e.rdata);
                if (e.chk_lat) check("rsp_latency", 32'(cyc - e.acc_cyc), 32'(RD_LAT + 1));
            end
        end
    endtask

    task automatic idle_bus();
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = 32'h0;
        req_be    = 4'h0;
    endtask

    // Hold a request until accepted, check the RAM pins and record the expected response.
    task automatic send(input logic we, input logic [AW-1:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic use_exp, input logic [31:0] exp_rd,
                        output int waits);
        exp_t e;
        bit   ok;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        waits     = 0;
        ok        = 1'b0;
        while (!ok && waits <= 100) begin
            tick();
            if (req_ready) begin
                ok = 1'b1;
            end else begin
                waits++;
                next_edge();
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no accept for addr 0x%03h expected accept within 100 cycles", addr);
            req_valid = 1'b0;
            return;
        end
        check("sram_req", 32'(sram_req), 32'd1);
        check("sram_we", 32'(sram_we), 32'(we));
        check("sram_addr", 32'(sram_addr), 32'(addr));
        check("sram_wdata", sram_wdata, wd);
        check("sram_be", 32'(sram_be), we ? 32'(be) : 32'd0);
        e.we      = we;
        e.rdata   = we ? 32'h0 : (use_exp ? exp_rd : shadow[addr]);
        e.acc_cyc = cyc;
        e.chk_lat = lat_chk;
        sb.push_back(e);
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) shadow[addr][8*b +: 8] = wd[8*b +: 8];
            end
        end
        last_acc_cyc = cyc;
        next_edge();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            tick();
            next_edge();
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[9];
        int          w;
        logic [31:0] head_exp;

        vecs[0] = '{1'b1, 10'h010, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 10'h010, 32'h12345678, 4'hF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 10'h3FF, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 10'h3FF, 32'h11223344, 4'h5, 32'h0};
        vecs[4] = '{1'b0, 10'h3FF, 32'h0,        4'hF, 32'hFF22FF44};
        vecs[5] = '{1'b1, 10'h000, 32'h0BADF00D, 4'hF, 32'h0};
        vecs[6] = '{1'b1, 10'h000, 32'hFFFFFFFF, 4'h0, 32'h0};
        vecs[7] = '{1'b1, 10'h3FF, 32'hA0B0C0D0, 4'h8, 32'h0};
        vecs[8] = '{1'b0, 10'h000, 32'h0,        4'h0, 32'h0BADF00D};

        // Reset with a request presented: nothing may be accepted or reach the RAM.
        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h003;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        rsp_ready = 1'b1;
        next_edge();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_req_ready", 32'(req_ready), 32'd0);
            check("rst_sram_req", 32'(sram_req), 32'd0);
            next_edge();
        end
        rst = 1'b0;
        idle_bus();
        tick();
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("post_rst_idle", 32'(idle), 32'd1);
        check("post_rst_rsp_we", 32'(rsp_we), 32'd0);
        check("post_rst_rsp_rdata", rsp_rdata, 32'h0);
        next_edge();

        // Table: writes, partial writes, be=0 write and read-backs, back to back.
        lat_chk = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, !vecs[i].we, vecs[i].exp_rd, w);
        end
        idle_bus();
        tick();
        check("idle_sram_req", 32'(sram_req), 32'd0);
        check("idle_sram_we", 32'(sram_we), 32'd0);
        check("idle_sram_be", 32'(sram_be), 32'd0);
        check("idle_sram_addr", 32'(sram_addr), 32'd0);
        next_edge();
        drain();

        // Streaming: 64 writes then 64 reads, one per cycle, no stalls allowed.
        for (int i = 0; i < 64; i++) begin
            send(1'b1, AW'(i + 256), 32'hC0DE0000 ^ (32'(i) * 32'h00010003), 4'hF, 1'b0, 32'h0, w);
            if (i > 0) check("stream_wr_wait", 32'(w), 32'd0);
        end
        for (int i = 0; i < 64; i++) begin
            send(1'b0, AW'(i + 256), 32'h0, 4'h0, 1'b0, 32'h0, w);
            check("stream_rd_wait", 32'(w), 32'd0);
        end
        idle_bus();
        drain();
        check("stream_last_latency", 32'(last_pop_cyc - last_acc_cyc), 32'(RD_LAT + 1));

        // Backpressure: only RSP_DEPTH reads fit; head must hold steady.
        lat_chk   = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, AW'(i + 288), 32'h0, 4'h0, 1'b0, 32'h0, w);
            check("bp_accept_wait", 32'(w), 32'd0);
        end
        check("bp_accepted", 32'(sb.size()), 32'd4);
        head_exp  = sb[0].rdata;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = AW'(292);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("bp_ready_low", 32'(req_ready), 32'd0);
            check("bp_head_valid", 32'(rsp_valid), 32'd1);
            check("bp_head_data", rsp_rdata, head_exp);
            next_edge();
        end
        rsp_ready = 1'b1;
        tick();
        check("full_pop_ready_low", 32'(req_ready), 32'd0);
        next_edge();
        send(1'b0, AW'(292), 32'h0, 4'h0, 1'b0, 32'h0, w);
        check("full_next_ready", 32'(w), 32'd0);
        send(1'b0, AW'(293), 32'h0, 4'h0, 1'b0, 32'h0, w);
        idle_bus();
        drain();
        tick();
        check("bp_idle", 32'(idle), 32'd1);
        check("bp_rsp_valid_low", 32'(rsp_valid), 32'd0);
        next_edge();

        // Reset with three reads in flight: nothing stale may come out afterwards.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(1'b0, AW'(i + 304), 32'h0, 4'h0, 1'b0, 32'h0, w);
        end
        rst = 1'b1;
        tick();
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        check("midrst_sram_req", 32'(sram_req), 32'd0);
        sb.delete();
        next_edge();
        rst = 1'b0;
        idle_bus();
        tick();
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("midrst_idle", 32'(idle), 32'd1);
        check("midrst_ready", 32'(req_ready), 32'd1);
        next_edge();
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst_no_stale", 32'(rsp_valid), 32'd0);
            next_edge();
        end
        send(1'b0, AW'(305), 32'h0, 4'h0, 1'b0, 32'h0, w);
        idle_bus();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lmu_req_ctrl.md
Name: lmu_req_ctrl

Overview:
- Request front-end for the LMU single-port SRAM. Sits directly upstream of the RAM wrapper and drives its req/we/addr/wdata/be pins.
- Accepts 32-bit read/write requests over a valid/ready handshake.
- Tracks read latency and returns one in-order response per request through a credit-protected response FIFO, so consumer backpressure never loses RAM read data.

Parameters:
- NUM_WORDS, 1024, RAM depth; AW = $clog2(NUM_WORDS).
- RD_LAT, 1, RAM read latency in cycles: 1, or 2 when the RAM has output registers. Other values are an elaboration error.
- RSP_DEPTH, 4, response FIFO entries. Must be ≥ RD_LAT+2 for full throughput; elaboration error if < RD_LAT+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid & ready
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  AW  word address
- req_wdata_i  in  32  write data
- req_be_i  in  4  byte enables (writes only)
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_we_o  out  1  response belongs to a write
- rsp_rdata_o  out  32  read data; 0 for writes
- sram_req_o  out  1  RAM chip select
- sram_we_o  out  1  RAM write enable
- sram_addr_o  out  AW  RAM address
- sram_wdata_o  out  32  RAM write data
- sram_be_o  out  4  RAM byte enables
- sram_rdata_i  in  32  RAM read data
- idle_o  out  1  no requests in flight and FIFO empty

Behaviour:
- Reset (rst_i high at a clock edge):
  - Credit counter, latency shift register and FIFO are cleared.
  - After reset: req_ready_o=1 (RSP_DEPTH>0), rsp_valid_o=0, idle_o=1, rsp_we_o=0, rsp_rdata_o=0.
  - While rst_i is high, req_ready_o=0 and sram_req_o=0.
  - Reset mid-operation discards in-flight and buffered responses. RAM contents are not touched; writes already issued stay committed.
- Accept: acc = req_valid_i & req_ready_o.
- RAM drive, combinational in the accept cycle:
  - sram_req_o=acc, sram_we_o=req_we_i, sram_addr_o=req_addr_i, sram_wdata_o=req_wdata_i.
  - sram_be_o = req_be_i when writing, else 4'b0000.
  - When acc=0, all sram_* outputs other than sram_req_o hold 0.
- Latency pipe: shift register of RD_LAT stages carrying {valid, we}.
  - Stage RD_LAT is valid in cycle t+RD_LAT for a request accepted in cycle t.
  - In that cycle the FIFO pushes {we, we ? 32'h0 : sram_rdata_i}.
- Response: rsp_valid_o = FIFO not empty. rsp_valid_o first rises in cycle t+RD_LAT+1, so total latency is RD_LAT+1.
- FIFO output: registered head, not fall-through. rsp_* stay stable while rsp_valid_o=1 and rsp_ready_i=0.
- Credit counter cnt, range 0..RSP_DEPTH:
  - +1 on acc, −1 on pop; both in the same cycle leaves it unchanged.
  - req_ready_o = !rst_i & (cnt < RSP_DEPTH). It does not depend combinationally on rsp_ready_i or req_valid_i.
- FIFO overflow is impossible by construction. Push while full is an assertion error.
- Push and pop in the same cycle are both honoured, including when the FIFO is full (pop frees the slot) or empty (FIFO is non-empty the next cycle).
- Ordering: responses leave strictly in acceptance order; reads and writes share one queue.
- Wrap-around: FIFO pointers are log2(RSP_DEPTH)+1 bits, or modulo counters for non-power-of-2 depths. Address wrap is not applicable, since the address is exactly AW bits.
- idle_o = (cnt==0).
- Back-to-back: with RSP_DEPTH ≥ RD_LAT+2 and rsp_ready_i held high, one request is accepted every cycle indefinitely.

Decomposition:
- Package lmu_pkg:
  - LMU_DW=32, LMU_BEW=4.
  - typedef lmu_rsp_t {we, rdata}.
  - typedef lmu_req_t {we, addr (parameterised via AW in the module), wdata, be}.
- Sub-module lmu_rsp_fifo: synchronous FIFO of lmu_rsp_t with depth RSP_DEPTH, ports push/pop/full/empty, same clk_i/rst_i.
- Latency pipe and credit counter stay in the top.

Test Plan:
- Write 0xDEADBEEF, be=4'hF, addr 0x010; then read addr 0x010 → write response (rsp_we_o=1, rdata=0) in cycle 2, read response rdata=0xDEADBEEF in cycle 3 (RD_LAT=1).
- Partial write be=4'b0101, data 0x11223344 over 0xFFFFFFFF at addr 0x3FF, then read → 0xFF22FF44; sram_be_o=0 during the read.
- Streaming: 64 reads to consecutive addresses with rsp_ready_i=1, RD_LAT=2, RSP_DEPTH=4 → req_ready_o never drops after the first accept; 64 in-order responses; last one arrives 3 cycles after the last accept.
- Backpressure: rsp_ready_i=0, issue 6 reads with RSP_DEPTH=4 → exactly 4 accepted, req_ready_o=0 afterwards, head data stable. Release rsp_ready_i → remaining 2 accepted, all 6 correct and in order.
- Simultaneous push/pop at full: cnt=4, assert rsp_ready_i and req_valid_i in the same cycle → ready remains 0 that cycle, 1 the next; no loss or duplicate.
- Reset mid-operation: 3 reads in flight, pulse rst_i for 1 cycle → rsp_valid_o=0, idle_o=1, req_ready_o=1 the next cycle; no stale responses appear; a subsequent read returns correct data.
